ring_node_controller: RTL and testbench

- Per-node injection/ejection controller for one circular_memory_unit stop on the memory ring.
- Inspects the packet passing the stop each cycle. It ejects packets addressed to this node into a local eject FIFO.
- It injects queued local packets into empty or freed slots by driving the unit's overwrite and *_req_in fields.
- The ring never stalls. The controller only decides per cycle whether to replace the passing slot.

---
 rtl/ring_node_controller.sv | 162 ++++++++++++++++
 tb/tb_ring_node_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_node_controller.sv
// Injection/ejection controller for one stop on the memory ring.
// Ejects matching packets into a local FIFO; injects queued packets into free slots.
module ring_node_controller #(
    parameter int          DATA_W       = 512,
    parameter logic [4:0]  NODE_ID      = 5'd0,
    parameter logic [7:0]  EJECT_MASK   = 8'b0001_1000,
    parameter int          INJ_DEPTH    = 4,
    parameter int          EJ_DEPTH     = 2,
    parameter int          STARVE_LIMIT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [35:0]                  addr_ring_in,
    input  logic [DATA_W-1:0]            data_ring_in,
    input  logic [4:0]                   id_ring_in,
    input  logic [2:0]                   type_ring_in,
    output logic                         overwrite,
    output logic [35:0]                  addr_ring_out,
    output logic [DATA_W-1:0]            data_ring_out,
    output logic [4:0]                   id_ring_out,
    output logic [2:0]                   type_ring_out,
    input  logic                         inj_valid,
    output logic                         inj_ready,
    input  logic [35:0]                  inj_addr,
    input  logic [DATA_W-1:0]            inj_data,
    input  logic [4:0]                   inj_id,
    input  logic [2:0]                   inj_type,
    output logic                         ej_valid,
    input  logic                         ej_ready,
    output logic [35:0]                  ej_addr,
    output logic [DATA_W-1:0]            ej_data,
    output logic [4:0]                   ej_id,
    output logic [2:0]                   ej_type,
    output logic [$clog2(INJ_DEPTH):0]   inj_count,
    output logic                         starved,
    output logic                         err_inj_empty
);

    localparam int IW = $clog2(INJ_DEPTH);
    localparam int EW = $clog2(EJ_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [IW:0]   INJ_FULL   = (IW+1)'(INJ_DEPTH);
    localparam logic [EW:0]   EJ_FULL    = (EW+1)'(EJ_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [35:0]       inj_addr_q [INJ_DEPTH];
    logic [DATA_W-1:0] inj_data_q [INJ_DEPTH];
    logic [4:0]        inj_id_q   [INJ_DEPTH];
    logic [2:0]        inj_type_q [INJ_DEPTH];
    logic [IW-1:0]     inj_wr_ptr;
    logic [IW-1:0]     inj_rd_ptr;

    logic [35:0]       ej_addr_q [EJ_DEPTH];
    logic [DATA_W-1:0] ej_data_q [EJ_DEPTH];
    logic [4:0]        ej_id_q   [EJ_DEPTH];
    logic [2:0]        ej_type_q [EJ_DEPTH];
    logic [EW-1:0]     ej_wr_ptr;
    logic [EW-1:0]     ej_rd_ptr;
    logic [EW:0]       ej_count;

    logic [SW-1:0]     starve_cnt;

    logic slot_valid;
    logic eject_hit;
    logic slot_free;
    logic inject;
    logic inj_push;
    logic inj_bad;
    logic ej_pop;

    // Gating with rst lets a slot pass untouched while reset is held.
    assign slot_valid = (type_ring_in != 3'd0);
    assign eject_hit  = rst & slot_valid & (id_ring_in == NODE_ID)
                      & EJECT_MASK[type_ring_in] & (ej_count < EJ_FULL);
    assign slot_free  = !slot_valid | eject_hit;
    assign inject     = rst & slot_free & (inj_count != '0);

    assign inj_ready  = rst & (inj_count < INJ_FULL);
    assign inj_push   = inj_valid & inj_ready & (inj_type != 3'd0);
    assign inj_bad    = inj_valid & inj_ready & (inj_type == 3'd0);

    assign ej_valid   = (ej_count != '0);
    assign ej_pop     = ej_valid & ej_ready;
    assign ej_addr    = ej_addr_q[ej_rd_ptr];
    assign ej_data    = ej_data_q[ej_rd_ptr];
    assign ej_id      = ej_id_q[ej_rd_ptr];
    assign ej_type    = ej_type_q[ej_rd_ptr];

    assign overwrite  = eject_hit | inject;
    assign starved    = (starve_cnt == STARVE_MAX);

    always_comb begin
        addr_ring_out = '0;
        data_ring_out = '0;
        id_ring_out   = '0;
        type_ring_out = '0;
        if (inject) begin
            addr_ring_out = inj_addr_q[inj_rd_ptr];
            data_ring_out = inj_data_q[inj_rd_ptr];
            id_ring_out   = inj_id_q[inj_rd_ptr];
            type_ring_out = inj_type_q[inj_rd_ptr];
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the counts.
    always_ff @(posedge clk) begin
        if (inj_push) begin
            inj_addr_q[inj_wr_ptr] <= inj_addr;
            inj_data_q[inj_wr_ptr] <= inj_data;
            inj_id_q[inj_wr_ptr]   <= inj_id;
            inj_type_q[inj_wr_ptr] <= inj_type;
        end
        if (eject_hit) begin
            ej_addr_q[ej_wr_ptr] <= addr_ring_in;
            ej_data_q[ej_wr_ptr] <= data_ring_in;
            ej_id_q[ej_wr_ptr]   <= id_ring_in;
            ej_type_q[ej_wr_ptr] <= type_ring_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_wr_ptr <= '0;
            inj_rd_ptr <= '0;
            inj_count  <= '0;
        end else begin
            if (inj_push) inj_wr_ptr <= inj_wr_ptr + 1'b1;
            if (inject)   inj_rd_ptr <= inj_rd_ptr + 1'b1;
            inj_count <= inj_count + (IW+1)'(inj_push)
                                   - (IW+1)'(inject);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_wr_ptr <= '0;
            ej_rd_ptr <= '0;
            ej_count  <= '0;
        end else begin
            if (eject_hit) ej_wr_ptr <= ej_wr_ptr + 1'b1;
            if (ej_pop)    ej_rd_ptr <= ej_rd_ptr + 1'b1;
            ej_count <= ej_count + (EW+1)'(eject_hit)
                                 - (EW+1)'(ej_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt    <= '0;
            err_inj_empty <= 1'b0;
        end else begin
            if (inject || inj_count == '0)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
            if (inj_bad)
                err_inj_empty <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ring_node_controller.sv
// Directed bench for ring_node_controller.
// Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
module tb_ring_node_controller;

    localparam int DATA_W = 512;

    logic              clk;
    logic              rst;
    logic [35:0]       addr_ring_in;
    logic [DATA_W-1:0] data_ring_in;
    logic [4:0]        id_ring_in;
    logic [2:0]        type_ring_in;
    logic              overwrite;
    logic [35:0]       addr_ring_out;
    logic [DATA_W-1:0] data_ring_out;
    logic [4:0]        id_ring_out;
    logic [2:0]        type_ring_out;
    logic              inj_valid;
    logic              inj_ready;
    logic [35:0]       inj_addr;
    logic [DATA_W-1:0] inj_data;
    logic [4:0]        inj_id;
    logic [2:0]        inj_type;
    logic              ej_valid;
    logic              ej_ready;
    logic [35:0]       ej_addr;
    logic [DATA_W-1:0] ej_data;
    logic [4:0]        ej_id;
    logic [2:0]        ej_type;
    logic [2:0]        inj_count;
    logic              starved;
    logic              err_inj_empty;

    int checks = 0;
    int errors = 0;

    ring_node_controller dut (
        .clk          (clk),
        .rst          (rst),
        .addr_ring_in (addr_ring_in),
        .data_ring_in (data_ring_in),
        .id_ring_in   (id_ring_in),
        .type_ring_in (type_ring_in),
        .overwrite    (overwrite),
        .addr_ring_out(addr_ring_out),
        .data_ring_out(data_ring_out),
        .id_ring_out  (id_ring_out),
        .type_ring_out(type_ring_out),
        .inj_valid    (inj_valid),
        .inj_ready    (inj_ready),
        .inj_addr     (inj_addr),
        .inj_data     (inj_data),
        .inj_id       (inj_id),
        .inj_type     (inj_type),
        .ej_valid     (ej_valid),
        .ej_ready     (ej_ready),
        .ej_addr      (ej_addr),
        .ej_data      (ej_data),
        .ej_id        (ej_id),
        .ej_type      (ej_type),
        .inj_count    (inj_count),
        .starved      (starved),
        .err_inj_empty(err_inj_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ring(input logic [2:0] t, input logic [4:0] id,
                        input logic [35:0] a, input logic [63:0] d);
        type_ring_in = t;
        id_ring_in   = id;
        addr_ring_in = a;
        data_ring_in = DATA_W'(d);
    endtask

    task automatic push(input logic [2:0] t, input logic [4:0] id,
                        input logic [35:0] a, input logic [63:0] d);
        inj_valid = 1'b1;
        inj_type  = t;
        inj_id    = id;
        inj_addr  = a;
        inj_data  = DATA_W'(d);
    endtask

    initial begin
        rst       = 1'b0;
        inj_valid = 1'b0;
        inj_type  = '0;
        inj_id    = '0;
        inj_addr  = '0;
        inj_data  = '0;
        ej_ready  = 1'b0;
        ring(3'd3, 5'd0, 36'h5, 64'h11);
        #1;
        // Matching slot during reset must pass untouched.
        chk("rst_overwrite", 64'(overwrite), 64'd0);
        chk("rst_type_out", 64'(type_ring_out), 64'd0);
        chk("rst_inj_ready", 64'(inj_ready), 64'd0);
        chk("rst_ej_valid", 64'(ej_valid), 64'd0);
        chk("rst_inj_count", 64'(inj_count), 64'd0);
        chk("rst_starved", 64'(starved), 64'd0);
        chk("rst_err", 64'(err_inj_empty), 64'd0);
        tick();
        tick();
        ring(3'd0, 5'd0, 36'h0, 64'h0);
        rst = 1'b1;
        #1;
        chk("post_rst_inj_ready", 64'(inj_ready), 64'd1);
        chk("post_rst_ej_valid", 64'(ej_valid), 64'd0);

        // Single inject into an empty slot.
        push(3'd1, 5'd3, 36'h10, 64'h55);
        #1;
        chk("t1_no_ow_before", 64'(overwrite), 64'd0);
        tick();
        inj_valid = 1'b0;
        #1;
        chk("t1_count1", 64'(inj_count), 64'd1);
        chk("t1_ow", 64'(overwrite), 64'd1);
        chk("t1_type_out", 64'(type_ring_out), 64'd1);
        chk("t1_id_out", 64'(id_ring_out), 64'd3);
        chk("t1_addr_out", 64'(addr_ring_out), 64'h10);
        chk("t1_data_out", data_ring_out[63:0], 64'h55);
        tick();
        chk("t1_count0", 64'(inj_count), 64'd0);
        chk("t1_ow_after", 64'(overwrite), 64'd0);

        // Eject only: slot is replaced with EMPTY.
        ring(3'd3, 5'd0, 36'h20, 64'hAB);
        #1;
        chk("t2_ow", 64'(overwrite), 64'd1);
        chk("t2_type_out", 64'(type_ring_out), 64'd0);
        chk("t2_data_out", data_ring_out[63:0], 64'd0);
        tick();
        ring(3'd0, 5'd0, 36'h0, 64'h0);
        #1;
        chk("t2_ej_valid", 64'(ej_valid), 64'd1);
        chk("t2_ej_data", ej_data[63:0], 64'hAB);
        chk("t2_ej_type", 64'(ej_type), 64'd3);
        chk("t2_ej_addr", 64'(ej_addr), 64'h20);
        ej_ready = 1'b1;
        tick();
        ej_ready = 1'b0;
        #1;
        chk("t2_ej_popped", 64'(ej_valid), 64'd0);

        // Eject and inject in the same cycle.
        ring(3'd4, 5'd5, 36'h1, 64'h1);
        push(3'd2, 5'd7, 36'h30, 64'h77);
        tick();
        inj_valid = 1'b0;
        #1;
        chk("t3_pass_nonmatch", 64'(overwrite), 64'd0);
        chk("t3_count1", 64'(inj_count), 64'd1);
        ring(3'd4, 5'd0, 36'h31, 64'hCD);
        #1;
        chk("t3_ow", 64'(overwrite), 64'd1);
        chk("t3_type_out", 64'(type_ring_out), 64'd2);
        chk("t3_addr_out", 64'(addr_ring_out), 64'h30);
        tick();
        ring(3'd0, 5'd0, 36'h0, 64'h0);
        #1;
        chk("t3_count0", 64'(inj_count), 64'd0);
        chk("t3_ej_valid", 64'(ej_valid), 64'd1);
        chk("t3_ej_type", 64'(ej_type), 64'd4);
        chk("t3_ej_data", ej_data[63:0], 64'hCD);
        ej_ready = 1'b1;
        tick();
        ej_ready = 1'b0;
        #1;
        chk("t3_ej_popped", 64'(ej_valid), 64'd0);

        // Eject FIFO full: matching packet circulates.
        ring(3'd3, 5'd0, 36'h41, 64'h1);
        tick();
        ring(3'd3, 5'd0, 36'h42, 64'h2);
        tick();
        ring(3'd3, 5'd0, 36'h43, 64'h3);
        #1;
        chk("t4_full_ow", 64'(overwrite), 64'd0);
        chk("t4_head", ej_data[63:0], 64'h1);
        tick();
        chk("t4_head_hold", ej_data[63:0], 64'h1);
        ring(3'd0, 5'd0, 36'h0, 64'h0);
        ej_ready = 1'b1;
        tick();
        chk("t4_second_valid", 64'(ej_valid), 64'd1);
        chk("t4_second", ej_data[63:0], 64'h2);
        chk("t4_second_addr", 64'(ej_addr), 64'h42);
        tick();
        chk("t4_drained", 64'(ej_valid), 64'd0);
        ej_ready = 1'b0;

        // Starvation under a continuous stream of foreign packets.
        ring(3'd1, 5'd9, 36'h50, 64'h5);
        push(3'd5, 5'd2, 36'h40, 64'h99);
        tick();
        inj_valid = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        chk("t5_not_yet", 64'(starved), 64'd0);
        tick();
        chk("t5_starved", 64'(starved), 64'd1);
        chk("t5_blocked_ow", 64'(overwrite), 64'd0);
        ring(3'd0, 5'd0, 36'h0, 64'h0);
        #1;
        chk("t5_inject_ow", 64'(overwrite), 64'd1);
        chk("t5_type_out", 64'(type_ring_out), 64'd5);
        tick();
        chk("t5_starve_clr", 64'(starved), 64'd0);
        chk("t5_count0", 64'(inj_count), 64'd0);

        // Fill inject FIFO, EMPTY-type push, then mid-stream reset.
        ring(3'd1, 5'd9, 36'h50, 64'h5);
        for (int i = 0; i < 4; i++) begin
            push(3'(i + 1), 5'(i), 36'h100 + 36'(i), 64'(i));
            tick();
        end
        inj_valid = 1'b0;
        #1;
        chk("t6_count4", 64'(inj_count), 64'd4);
        chk("t6_not_ready", 64'(inj_ready), 64'd0);
        ring(3'd0, 5'd0, 36'h0, 64'h0);
        #1;
        chk("t6_first_addr", 64'(addr_ring_out), 64'h100);
        chk("t6_first_type", 64'(type_ring_out), 64'd1);
        tick();
        ring(3'd1, 5'd9, 36'h50, 64'h5);
        #1;
        chk("t6_count3", 64'(inj_count), 64'd3);
        chk("t6_ready", 64'(inj_ready), 64'd1);
        push(3'd0, 5'd1, 36'h1FF, 64'hFF);
        tick();
        inj_valid = 1'b0;
        #1;
        chk("t6_err", 64'(err_inj_empty), 64'd1);
        chk("t6_count_kept", 64'(inj_count), 64'd3);
        ring(3'd3, 5'd0, 36'h60, 64'hEE);
        #1;
        chk("t6_second_type", 64'(type_ring_out), 64'd2);
        chk("t6_second_addr", 64'(addr_ring_out), 64'h101);
        tick();
        chk("t6_ej_valid", 64'(ej_valid), 64'd1);
        chk("t6_ej_data", ej_data[63:0], 64'hEE);
        chk("t6_count2", 64'(inj_count), 64'd2);
        chk("t6_err_sticky", 64'(err_inj_empty), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_count", 64'(inj_count), 64'd0);
        chk("t6_rst_ej_valid", 64'(ej_valid), 64'd0);
        chk("t6_rst_ow", 64'(overwrite), 64'd0);
        chk("t6_rst_type_out", 64'(type_ring_out), 64'd0);
        chk("t6_rst_err", 64'(err_inj_empty), 64'd0);
        chk("t6_rst_ready", 64'(inj_ready), 64'd0);
        chk("t6_rst_starved", 64'(starved), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
